// File: rtl/aes_block_sequencer.sv
// Byte-serial front end for the AES core: packs input bytes into 128-bit blocks, pads short
// blocks, starts the core, waits for done and streams the ciphertext back out MSB byte first.
module aes_block_sequencer #(
  parameter logic [7:0]  PAD_BYTE = 8'h20,
  parameter int unsigned TIMEOUT  = 0
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [7:0]   in_byte,
  input  logic         in_valid,
  input  logic         in_last,
  output logic         in_ready,
  output logic [127:0] aes_plain_text,
  output logic         aes_start,
  input  logic         aes_done,
  input  logic [127:0] aes_cipher_text,
  output logic [7:0]   out_byte,
  output logic         out_valid,
  output logic         out_last,
  input  logic         out_ready,
  output logic         busy,
  output logic [15:0]  blocks_done
);

  localparam int unsigned TW = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;

  typedef enum logic [2:0] {StFill, StPad, StStart, StWait, StDrain} state_e;

  state_e         state_q, state_d;
  logic [3:0]     cnt_q, cnt_d;
  logic [3:0]     ocnt_q, ocnt_d;
  logic [TW-1:0]  idle_q, idle_d;
  logic [127:0]   pt_q, pt_d;
  logic [127:0]   sr_q, sr_d;
  logic [15:0]    blocks_q, blocks_d;
  logic           accept, out_hs, lane_we;
  logic [7:0]     lane_data;

  assign in_ready       = (state_q == StFill);
  assign accept         = in_valid && in_ready;
  assign aes_start      = (state_q == StStart);
  assign out_valid      = (state_q == StDrain);
  assign out_hs         = out_valid && out_ready;
  assign out_last       = out_valid && (ocnt_q == 4'd15);
  assign out_byte       = sr_q[127:120];
  assign busy           = !((state_q == StFill) && (cnt_q == 4'd0));
  assign aes_plain_text = pt_q;
  assign blocks_done    = blocks_q;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    ocnt_d    = ocnt_q;
    idle_d    = idle_q;
    pt_d      = pt_q;
    sr_d      = sr_q;
    blocks_d  = blocks_q;
    lane_we   = 1'b0;
    lane_data = in_byte;

    unique case (state_q)
      StFill: begin
        if (accept) begin
          lane_we = 1'b1;
          cnt_d   = cnt_q + 4'd1;
          idle_d  = '0;
          if (cnt_q == 4'd15) begin
            state_d = StStart;
          end else if (in_last) begin
            state_d = StPad;
          end
        end else if ((TIMEOUT > 0) && (cnt_q != 4'd0)) begin
          // Timer value N means N idle cycles have already elapsed.
          if (idle_q == TW'(TIMEOUT - 1)) begin
            idle_d  = '0;
            state_d = StPad;
          end else begin
            idle_d = idle_q + 1'b1;
          end
        end else begin
          idle_d = '0;
        end
      end
      StPad: begin
        lane_we   = 1'b1;
        lane_data = PAD_BYTE;
        cnt_d     = cnt_q + 4'd1;
        if (cnt_q == 4'd15) state_d = StStart;
      end
      StStart: state_d = StWait;
      StWait: begin
        if (aes_done) begin
          sr_d    = aes_cipher_text;
          ocnt_d  = 4'd0;
          state_d = StDrain;
        end
      end
      StDrain: begin
        if (out_hs) begin
          sr_d   = {sr_q[119:0], 8'h00};
          ocnt_d = ocnt_q + 4'd1;
          if (ocnt_q == 4'd15) begin
            blocks_d = blocks_q + 16'd1;
            cnt_d    = 4'd0;
            state_d  = StFill;
          end
        end
      end
      default: state_d = StFill;
    endcase

    // Byte k lands in the k-th most significant byte lane.
    for (int k = 0; k < 16; k++) begin
      if (lane_we && (cnt_q == 4'(k))) pt_d[127-8*k -: 8] = lane_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= StFill;
      cnt_q    <= 4'd0;
      ocnt_q   <= 4'd0;
      idle_q   <= '0;
      pt_q     <= '0;
      sr_q     <= '0;
      blocks_q <= 16'd0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      ocnt_q   <= ocnt_d;
      idle_q   <= idle_d;
      pt_q     <= pt_d;
      sr_q     <= sr_d;
      blocks_q <= blocks_d;
    end
  end

endmodule

// File: tb/tb_aes_block_sequencer.sv
// Self-checking bench for aes_block_sequencer: random blocks against a byte-queue reference
// model, plus padding, timeout, backpressure and reset-abort scenarios.
module tb_aes_block_sequencer;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         rst_n;
  logic [7:0]   in_byte;
  logic         in_valid, in_last, in_ready;
  logic [127:0] aes_plain_text, aes_cipher_text;
  logic         aes_start, aes_done;
  logic [7:0]   out_byte;
  logic         out_valid, out_last, out_ready, busy;
  logic [15:0]  blocks_done;

  logic         t_rst_n;
  logic [7:0]   t_in_byte;
  logic         t_in_valid, t_in_last, t_in_ready;
  logic [127:0] t_plain, t_cipher;
  logic         t_aes_start, t_aes_done;
  logic [7:0]   t_out_byte;
  logic         t_out_valid, t_out_last, t_out_ready, t_busy;
  logic [15:0]  t_blocks_done;

  aes_block_sequencer dut (
    .clk(clk), .rst_n(rst_n), .in_byte(in_byte), .in_valid(in_valid), .in_last(in_last),
    .in_ready(in_ready), .aes_plain_text(aes_plain_text), .aes_start(aes_start),
    .aes_done(aes_done), .aes_cipher_text(aes_cipher_text), .out_byte(out_byte),
    .out_valid(out_valid), .out_last(out_last), .out_ready(out_ready), .busy(busy),
    .blocks_done(blocks_done)
  );

  aes_block_sequencer #(.PAD_BYTE(8'h20), .TIMEOUT(8)) dut_to (
    .clk(clk), .rst_n(t_rst_n), .in_byte(t_in_byte), .in_valid(t_in_valid),
    .in_last(t_in_last), .in_ready(t_in_ready), .aes_plain_text(t_plain),
    .aes_start(t_aes_start), .aes_done(t_aes_done), .aes_cipher_text(t_cipher),
    .out_byte(t_out_byte), .out_valid(t_out_valid), .out_last(t_out_last),
    .out_ready(t_out_ready), .busy(t_busy), .blocks_done(t_blocks_done)
  );

  int          n_checks = 0;
  int          n_fail = 0;
  int          cyc = 0;
  int          start_cnt = 0;
  logic [15:0] bd_exp = 16'd0;
  logic [15:0] t_bd_exp = 16'd0;
  logic [7:0]  msg [16];

  always @(posedge clk) cyc++;
  always @(negedge clk) if (aes_start === 1'b1) start_cnt++;

  // Reference: message bytes in order, short tail filled with ASCII space.
  function automatic logic [127:0] pack(input int n);
    logic [127:0] v = '0;
    for (int k = 0; k < 16; k++) v = {v[119:0], (k < n) ? msg[k] : 8'h20};
    return v;
  endfunction

  function automatic logic [127:0] rand128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  task automatic rand_msg();
    for (int i = 0; i < 16; i++) msg[i] = 8'($urandom_range(32, 126));
  endtask

  // Sends msg[first..n-1], stubs the core and drains; starts and ends on a negedge.
  task automatic run_block(input int first, input int n, input bit use_last, input bit bp,
                           input int dly, input logic [127:0] cipher);
    int s0, pres_cyc, t, idx, lat;
    bit r;
    logic [127:0] exp_pt, sh;
    s0 = start_cnt;
    pres_cyc = cyc;
    for (int i = first; i < n; i++) begin
      n_checks++;
      if (in_ready !== 1'b1) begin
        n_fail++; $display("FAIL fill_ready byte %0d: got %b expected 1", i, in_ready);
      end
      in_valid = 1'b1; in_byte = msg[i]; in_last = use_last && (i == n - 1);
      pres_cyc = cyc;
      @(negedge clk);
    end
    in_valid = 1'b0; in_last = 1'b0;
    t = 0;
    while (aes_start !== 1'b1 && t < 40) begin @(negedge clk); t++; end
    lat = cyc - pres_cyc;
    n_checks++;
    if (aes_start !== 1'b1 || lat != ((n == 16) ? 1 : 17 - n)) begin
      n_fail++; $display("FAIL start_latency: got %0d expected %0d", lat, (n == 16) ? 1 : 17 - n);
    end
    exp_pt = pack(n);
    n_checks++;
    if (aes_plain_text !== exp_pt) begin
      n_fail++; $display("FAIL plain_text: got %h expected %h", aes_plain_text, exp_pt);
    end
    repeat (dly) begin
      @(negedge clk);
      n_checks++;
      if (in_ready !== 1'b0 || out_valid !== 1'b0 || aes_start !== 1'b0) begin
        n_fail++;
        $display("FAIL wait_state: got ready=%b valid=%b start=%b expected 0 0 0",
                 in_ready, out_valid, aes_start);
      end
    end
    n_checks++;
    if (aes_plain_text !== exp_pt) begin
      n_fail++; $display("FAIL plain_stable: got %h expected %h", aes_plain_text, exp_pt);
    end
    aes_done = 1'b1; aes_cipher_text = cipher;
    @(negedge clk);
    aes_done = 1'b0; aes_cipher_text = rand128();
    idx = 0; t = 0;
    while (idx < 16 && t < 300) begin
      sh = cipher >> (8 * (15 - idx));
      n_checks++;
      if (out_valid !== 1'b1 || out_byte !== sh[7:0] || out_last !== (idx == 15) ||
          in_ready !== 1'b0) begin
        n_fail++;
        $display("FAIL drain byte %0d: got v=%b b=%h l=%b r=%b expected 1 %h %b 0",
                 idx, out_valid, out_byte, out_last, in_ready, sh[7:0], idx == 15);
      end
      r = bp ? 1'($urandom_range(0, 1)) : 1'b1;
      out_ready = r;
      @(negedge clk);
      t++;
      if (r) idx++;
    end
    out_ready = 1'b0;
    bd_exp++;
    n_checks++;
    if (idx != 16 || blocks_done !== bd_exp || out_valid !== 1'b0 || in_ready !== 1'b1 ||
        busy !== 1'b0) begin
      n_fail++;
      $display("FAIL block_end: got idx=%0d bd=%0d v=%b r=%b busy=%b expected 16 %0d 0 1 0",
               idx, blocks_done, out_valid, in_ready, busy, bd_exp);
    end
    n_checks++;
    if (start_cnt - s0 != 1) begin
      n_fail++; $display("FAIL start_count: got %0d expected 1", start_cnt - s0);
    end
  endtask

  task automatic check_reset_values(input string tag);
    n_checks++;
    if ({in_ready, aes_start, out_valid, out_last, busy} !== 5'b10000 ||
        aes_plain_text !== '0 || out_byte !== 8'h00 || blocks_done !== 16'd0) begin
      n_fail++;
      $display("FAIL %s: got r/s/v/l/b=%b pt=%h ob=%h bd=%0d expected 10000 0 00 0", tag,
               {in_ready, aes_start, out_valid, out_last, busy}, aes_plain_text, out_byte,
               blocks_done);
    end
  endtask

  task automatic test_reset();
    #1 check_reset_values("reset_async");
    @(negedge clk);
    rst_n = 1'b1; t_rst_n = 1'b1;
    @(negedge clk);
    check_reset_values("reset_release");
  endtask

  task automatic test_known_vector();
    logic [127:0] v = 128'h54776F204F6E65204E696E652054776F;
    for (int k = 0; k < 16; k++) msg[k] = v[127-8*k -: 8];
    run_block(0, 16, 1'b0, 1'b0, 5, 128'h29C3505F571420F6402299B31A02D73A);
  endtask

  task automatic test_short_pad();
    msg[0] = 8'h41; msg[1] = 8'h42; msg[2] = 8'h43;
    run_block(0, 3, 1'b1, 1'b0, 3, rand128());
  endtask

  task automatic test_full_last_backpressure();
    rand_msg();
    run_block(0, 16, 1'b1, 1'b1, $urandom_range(1, 6), rand128());
  endtask

  task automatic test_random_blocks();
    repeat (6) begin
      rand_msg();
      run_block(0, $urandom_range(1, 16), 1'b1, 1'b1, $urandom_range(1, 8), rand128());
    end
  endtask

  task automatic test_done_in_fill();
    aes_done = 1'b1; aes_cipher_text = rand128();
    @(negedge clk);
    aes_done = 1'b0;
    n_checks++;
    if ({out_valid, in_ready, busy} !== 3'b010 || blocks_done !== bd_exp) begin
      n_fail++;
      $display("FAIL done_idle: got v/r/b=%b bd=%0d expected 010 %0d",
               {out_valid, in_ready, busy}, blocks_done, bd_exp);
    end
    rand_msg();
    in_valid = 1'b1; in_byte = msg[0]; in_last = 1'b0;
    @(negedge clk);
    in_valid = 1'b0;
    aes_done = 1'b1;
    @(negedge clk);
    aes_done = 1'b0;
    repeat (2) @(negedge clk);
    n_checks++;
    if ({out_valid, in_ready, busy} !== 3'b011) begin
      n_fail++; $display("FAIL done_partial: got v/r/b=%b expected 011", {out_valid, in_ready, busy});
    end
    run_block(1, 10, 1'b1, 1'b0, 2, rand128());
  endtask

  task automatic test_reset_mid_wait();
    int t;
    rand_msg();
    for (int i = 0; i < 3; i++) begin
      in_valid = 1'b1; in_byte = msg[i]; in_last = (i == 2);
      @(negedge clk);
    end
    in_valid = 1'b0; in_last = 1'b0;
    t = 0;
    while (aes_start !== 1'b1 && t < 40) begin @(negedge clk); t++; end
    n_checks++;
    if (aes_start !== 1'b1) begin
      n_fail++; $display("FAIL abort_start: got %b expected 1", aes_start);
    end
    repeat (2) @(negedge clk);
    rst_n = 1'b0;
    #1 check_reset_values("reset_mid_wait");
    @(negedge clk);
    rst_n = 1'b1;
    bd_exp = 16'd0;
    @(negedge clk);
    aes_done = 1'b1; aes_cipher_text = rand128();
    @(negedge clk);
    aes_done = 1'b0;
    repeat (2) @(negedge clk);
    check_reset_values("stale_done");
    rand_msg();
    run_block(0, 16, 1'b0, 1'b1, 3, rand128());
  endtask

  task automatic t_send(input int first, input int n);
    for (int i = first; i < n; i++) begin
      t_in_valid = 1'b1; t_in_byte = msg[i]; t_in_last = 1'b0;
      @(negedge clk);
    end
    t_in_valid = 1'b0;
  endtask

  task automatic t_idle_ready(input int cycles, input string tag);
    for (int c = 1; c <= cycles; c++) begin
      n_checks++;
      if (t_in_ready !== 1'b1) begin
        n_fail++; $display("FAIL %s idle %0d: got ready=%b expected 1", tag, c, t_in_ready);
      end
      @(negedge clk);
    end
  endtask

  task automatic t_finish(input int n);
    int t;
    logic [127:0] exp_pt;
    n_checks++;
    if (t_in_ready !== 1'b0) begin
      n_fail++; $display("FAIL timeout_pad_entry: got ready=%b expected 0", t_in_ready);
    end
    t = 0;
    while (t_aes_start !== 1'b1 && t < 40) begin @(negedge clk); t++; end
    exp_pt = pack(n);
    n_checks++;
    if (t_aes_start !== 1'b1 || t_plain !== exp_pt) begin
      n_fail++; $display("FAIL timeout_plain: got %h expected %h", t_plain, exp_pt);
    end
    @(negedge clk);
    t_aes_done = 1'b1; t_cipher = rand128();
    @(negedge clk);
    t_aes_done = 1'b0;
    t_bd_exp++;
    t = 0;
    while (t_blocks_done !== t_bd_exp && t < 60) begin @(negedge clk); t++; end
    n_checks++;
    if (t_blocks_done !== t_bd_exp || t_in_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL timeout_block_end: got bd=%0d r=%b expected %0d 1",
               t_blocks_done, t_in_ready, t_bd_exp);
    end
  endtask

  task automatic test_timeout();
    rand_msg();
    t_send(0, 5);
    t_idle_ready(8, "timeout_a");
    t_finish(5);
    rand_msg();
    t_send(0, 5);
    t_idle_ready(6, "timeout_b");
    t_send(5, 6);
    t_idle_ready(8, "timeout_restart");
    t_finish(6);
  endtask

  initial begin
    rst_n = 1'b0; t_rst_n = 1'b0;
    in_byte = '0; in_valid = 1'b0; in_last = 1'b0; aes_done = 1'b0; aes_cipher_text = '0;
    out_ready = 1'b0;
    t_in_byte = '0; t_in_valid = 1'b0; t_in_last = 1'b0; t_aes_done = 1'b0; t_cipher = '0;
    t_out_ready = 1'b1;
    test_reset();
    test_known_vector();
    test_short_pad();
    test_full_last_backpressure();
    test_random_blocks();
    test_done_in_fill();
    test_reset_mid_wait();
    test_timeout();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
